// File: rtl/text_glyph_fetch.sv
// Text-mode pixel generator: text RAM and glyph ROM fetch, attribute decode,
// character blink and block cursor, in a 3-clock pipeline aligned with the syncs.
module text_glyph_fetch #(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter int unsigned CURSOR_FIRST = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [11:0] text_addr,
    input  logic [15:0] text_q,
    output logic [11:0] charset_addr,
    input  logic [7:0]  charset_q,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [3:0]  pix_color,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out
);

    localparam int unsigned AW = 12;
    localparam int unsigned BW = $clog2(BLINK_FRAMES);

    logic [6:0]    col;
    logic [4:0]    row;
    logic          in_range;
    logic          cursor_hit;

    logic          vs_q;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    logic          s1_valid_q, s1_de_q, s1_hs_q, s1_vs_q, s1_hit_q, s1_phase_q;
    logic [3:0]    s1_grow_q;
    logic [2:0]    s1_hsel_q;

    logic          s2_valid_q, s2_de_q, s2_hs_q, s2_vs_q, s2_hit_q, s2_phase_q;
    logic [7:0]    s2_attr_q;
    logic [2:0]    s2_hsel_q;

    logic          glyph_bit;
    logic [3:0]    pix_d;

    assign col = hcount[9:3];
    assign row = vcount[8:4];

    // y >= 512 would alias onto low rows through vcount[8:4], so it counts as off-screen
    assign in_range  = !vcount[9] && (32'(col) < COLS) && (32'(row) < ROWS);
    assign text_addr = in_range ? AW'(AW'(row) * AW'(COLS) + AW'(col)) : '0;

    assign cursor_hit = cursor_en && blink_q && (col == cursor_col) && (row == cursor_row)
                        && (vcount[3:0] >= 4'(CURSOR_FIRST));

    assign charset_addr = {text_q[7:0], s1_grow_q};

    // Frame counter advances on vsync rising edges; wrap toggles the blink phase
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (vs_in && !vs_q) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_d     = !blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Glyph bit: blink masking first, then cursor inversion
    always_comb begin
        glyph_bit = charset_q[~s2_hsel_q];
        pix_d     = '0;
        if (s2_attr_q[7] && !s2_phase_q) begin
            glyph_bit = 1'b0;
        end
        glyph_bit = glyph_bit ^ s2_hit_q;
        if (s2_valid_q) begin
            pix_d = glyph_bit ? s2_attr_q[3:0] : {1'b0, s2_attr_q[6:4]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q        <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_de_q     <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_phase_q  <= 1'b0;
            s1_grow_q   <= '0;
            s1_hsel_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_de_q     <= 1'b0;
            s2_hs_q     <= 1'b0;
            s2_vs_q     <= 1'b0;
            s2_hit_q    <= 1'b0;
            s2_phase_q  <= 1'b0;
            s2_attr_q   <= '0;
            s2_hsel_q   <= '0;
            pix_color   <= '0;
            de_out      <= 1'b0;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
        end else begin
            vs_q        <= vs_in;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;

            s1_valid_q  <= de_in && in_range;
            s1_de_q     <= de_in;
            s1_hs_q     <= hs_in;
            s1_vs_q     <= vs_in;
            s1_hit_q    <= cursor_hit;
            s1_phase_q  <= blink_q;
            s1_grow_q   <= vcount[3:0];
            s1_hsel_q   <= hcount[2:0];

            s2_valid_q  <= s1_valid_q;
            s2_de_q     <= s1_de_q;
            s2_hs_q     <= s1_hs_q;
            s2_vs_q     <= s1_vs_q;
            s2_hit_q    <= s1_hit_q;
            s2_phase_q  <= s1_phase_q;
            s2_attr_q   <= text_q[15:8];
            s2_hsel_q   <= s1_hsel_q;

            pix_color   <= pix_d;
            de_out      <= s2_de_q;
            hs_out      <= s2_hs_q;
            vs_out      <= s2_vs_q;
        end
    end

endmodule

// File: tb/tb_text_glyph_fetch.sv
// Scoreboard bench for text_glyph_fetch: directed pixels push expected colours,
// a negedge monitor pops and compares whenever de_out is high.
module tb_text_glyph_fetch;

    typedef struct packed {
        logic [3:0] pix;
        logic       hs;
        logic       vs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        de_in, hs_in, vs_in;
    logic [9:0]  hcount, vcount;
    logic [11:0] text_addr;
    logic [15:0] text_q;
    logic [11:0] charset_addr;
    logic [7:0]  charset_q;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [3:0]  pix_color;
    logic        de_out, hs_out, vs_out;

    logic [15:0] text_mem [4096];
    logic [7:0]  rom_mem  [4096];

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    text_glyph_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .de_in        (de_in),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .hcount       (hcount),
        .vcount       (vcount),
        .text_addr    (text_addr),
        .text_q       (text_q),
        .charset_addr (charset_addr),
        .charset_q    (charset_q),
        .cursor_en    (cursor_en),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
        .pix_color    (pix_color),
        .de_out       (de_out),
        .hs_out       (hs_out),
        .vs_out       (vs_out)
    );

    always #5 clk = ~clk;

    // Synchronous-read text RAM and glyph ROM
    always @(posedge clk) begin
        text_q    <= text_mem[text_addr];
        charset_q <= rom_mem[charset_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (de_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_de_out", 32'(de_out), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pix_color", 32'(pix_color), 32'(mon_e.pix));
                    chk("hs_out", 32'(hs_out), 32'(mon_e.hs));
                    chk("vs_out", 32'(vs_out), 32'(mon_e.vs));
                end
            end else begin
                chk("blank_pix", 32'(pix_color), 32'd0);
            end
        end
    end

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input int x, input int y, input logic [3:0] ep);
        @(posedge clk);
        #1;
        de_in  = de;
        hs_in  = hs;
        vs_in  = vs;
        hcount = 10'(x);
        vcount = 10'(y);
        if (de) exp_q.push_back('{ep, hs, vs});
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b0, 1'b1, 0, 0, 4'h0);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 4'h0);
    endtask

    initial begin
        int waited;
        rst        = 1'b1;
        de_in      = 1'b0;
        hs_in      = 1'b0;
        vs_in      = 1'b0;
        hcount     = '0;
        vcount     = '0;
        cursor_en  = 1'b0;
        cursor_col = 7'd5;
        cursor_row = 5'd2;
        for (int i = 0; i < 4096; i++) begin
            text_mem[i] = '0;
            rom_mem[i]  = '0;
        end
        text_mem[0]     = 16'h0F41;
        rom_mem[12'h410] = 8'h81;
        text_mem[2399]  = 16'h0742;
        rom_mem[12'h420] = 8'h80;
        text_mem[165]   = 16'h1F20;
        text_mem[1]     = 16'h8FDB;
        rom_mem[12'hDB0] = 8'hFF;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_pix", 32'(pix_color), 32'd0);
        chk("reset_de_out", 32'(de_out), 32'd0);
        chk("reset_hs_out", 32'(hs_out), 32'd0);
        chk("reset_vs_out", 32'(vs_out), 32'd0);
        rst = 1'b0;

        // Glyph 0x81 of cell 0: F,0,0,0,0,0,0,F with hsync pattern carried along
        for (int x = 0; x < 8; x++)
            drive(1'b1, 1'(x & 1), 1'b0, x, 0, (x == 0 || x == 7) ? 4'hF : 4'h0);

        // Last cell of the screen
        drive(1'b1, 1'b0, 1'b0, 632, 464, 4'h7);
        #1 chk("text_addr_2399", 32'(text_addr), 32'd2399);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 4'h0);
        #1 chk("charset_addr_420", 32'(charset_addr), 32'h420);

        // Off-screen and blanked pixels
        drive(1'b1, 1'b0, 1'b0, 640, 0, 4'h0);
        #1 chk("range_col80_addr", 32'(text_addr), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 0, 480, 4'h0);
        #1 chk("range_row30_addr", 32'(text_addr), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8, 0, 4'h0);

        // Cursor block on glyph rows 14..15 of cell (5,2)
        cursor_en = 1'b1;
        for (int x = 40; x < 48; x++) drive(1'b1, 1'b0, 1'b0, x, 46, 4'hF);
        for (int x = 40; x < 48; x++) drive(1'b1, 1'b0, 1'b0, x, 47, 4'hF);
        for (int x = 40; x < 48; x++) drive(1'b1, 1'b0, 1'b0, x, 45, 4'h1);
        drive(1'b1, 1'b0, 1'b0, 48, 46, 4'h0);

        // Blink: visible for frames 0..15, hidden after the 16th vsync edge
        drive(1'b1, 1'b0, 1'b0, 8, 0, 4'hF);
        for (int f = 1; f < 16; f++) begin
            vs_pulse();
            drive(1'b1, 1'b0, 1'b0, 8, 0, 4'hF);
        end
        vs_pulse();
        drive(1'b1, 1'b0, 1'b0, 8, 0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 40, 46, 4'h1);
        drive(1'b1, 1'b0, 1'b0, 47, 47, 4'h1);
        for (int f = 0; f < 15; f++) vs_pulse();
        drive(1'b1, 1'b0, 1'b0, 8, 0, 4'h0);

        // Reset in the middle of a line
        for (int x = 0; x < 4; x++) drive(1'b1, 1'b1, 1'b0, x, 0, (x == 0) ? 4'hF : 4'h0);
        #5;
        chk("pre_rst_pix", 32'(pix_color), 32'hF);
        chk("pre_rst_hs_out", 32'(hs_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_pix", 32'(pix_color), 32'd0);
        chk("rst_de_out", 32'(de_out), 32'd0);
        chk("rst_hs_out", 32'(hs_out), 32'd0);
        chk("rst_vs_out", 32'(vs_out), 32'd0);
        exp_q.delete();
        de_in  = 1'b1;
        hs_in  = 1'b1;
        vs_in  = 1'b0;
        hcount = '0;
        vcount = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back('{4'hF, 1'b1, 1'b0});
        #1;
        chk("post_rst0_de_out", 32'(de_out), 32'd0);
        chk("post_rst0_pix", 32'(pix_color), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1, 0, 4'h0);
        chk("post_rst1_de_out", 32'(de_out), 32'd0);
        chk("post_rst1_pix", 32'(pix_color), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 2, 0, 4'h0);
        chk("post_rst2_de_out", 32'(de_out), 32'd0);
        chk("post_rst2_pix", 32'(pix_color), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3, 0, 4'h0);

        // Blink counter restarted at 0 with phase visible
        drive(1'b1, 1'b0, 1'b0, 8, 0, 4'hF);
        for (int f = 0; f < 15; f++) vs_pulse();
        drive(1'b1, 1'b0, 1'b0, 8, 0, 4'hF);
        vs_pulse();
        drive(1'b1, 1'b0, 1'b0, 8, 0, 4'h0);

        drive(1'b0, 1'b0, 1'b0, 0, 0, 4'h0);
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
